// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and oversampling tick constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Tick indices within a 16x-oversampled bit: middle of the start bit, end of a full bit period.
    localparam int MID_TICK = 7;
    localparam int BIT_TICK = 15;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input, reset to a chosen level.
// Latency: 2 clk from an input edge to the output.
// Backpressure: none; the output follows the input every cycle.
module uart_rx_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            meta <= RST_VAL;
            o_q  <= RST_VAL;
        end else begin
            meta <= i_d;
            o_q  <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver driven by a 16x oversampling tick; good bytes strobe o_rxDone, bad stop bits strobe o_frameErr.
// Latency: strobes are registered and assert one clk after the deciding stop-bit tick.
// Backpressure: none; each strobe lasts one clk and o_data holds until the next good frame.
module uart_rx
    import uart_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int SB_TICK = 16,
    parameter int NB_TICK = 4
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rxDone,
    output logic               o_frameErr
);

    localparam int NB_CNT = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    logic rx_s;

    uart_rx_sync #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .i_rst (i_rst),
        .i_d   (i_rx),
        .o_q   (rx_s)
    );

    uart_state_t        state_q, state_d;
    logic [NB_TICK-1:0] s_q, s_d;
    logic [NB_CNT-1:0]  n_q, n_d;
    logic [NB_DATA-1:0] b_q, b_d;
    logic [NB_DATA-1:0] data_q, data_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // Leave on the falling edge itself; tick phase is irrelevant here.
                if (!rx_s) begin
                    s_d     = '0;
                    state_d = START;
                end
            end
            START: begin
                if (i_tick) begin
                    if (s_q == NB_TICK'(MID_TICK)) begin
                        if (!rx_s) begin
                            s_d     = '0;
                            n_d     = '0;
                            state_d = DATA;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (i_tick) begin
                    if (s_q == NB_TICK'(BIT_TICK)) begin
                        s_d = '0;
                        b_d = {rx_s, b_q[NB_DATA-1:1]};
                        if (n_q == NB_CNT'(NB_DATA - 1)) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (i_tick) begin
                    if (s_q == NB_TICK'(SB_TICK - 1)) begin
                        if (rx_s) begin
                            data_d = b_q;
                            done_d = 1'b1;
                        end else begin
                            err_d  = 1'b1;
                        end
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_data     = data_q;
    assign o_rxDone   = done_q;
    assign o_frameErr = err_q;

endmodule
